// File: rtl/peak_event_fifo.sv
// Peak event qualifier (width + refractory filters, wrapped interval) feeding a show-ahead FIFO.
// Optional running statistics ports are built when PEAK_FIFO_STATS_EN is defined.
module peak_event_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [13:0] MIN_GAP   = 14'd16,
  parameter logic [7:0]  MIN_WIDTH = 8'd2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pk_valid,
  input  logic [15:0]        pk_amp,
  input  logic [13:0]        pk_idx,
  input  logic [7:0]         pk_width,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_amp,
  output logic [13:0]        out_idx,
  output logic [7:0]         out_width,
  output logic [13:0]        out_interval,
  output logic               out_first,
  output logic [6:0]         fill_level,
  output logic [7:0]         drop_count,
  output logic [7:0]         reject_count,
  output logic               ovf_sticky,
`ifdef PEAK_FIFO_STATS_EN
  output logic signed [15:0] max_amp,
  output logic [15:0]        accept_count,
  output logic [13:0]        mean_interval,
`endif
  input  logic               clr_ovf
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] amp;
    logic [13:0] idx;
    logic [7:0]  width;
    logic [13:0] interval;
    logic        first;
  } evt_t;

  // Stage 1: qualification
  logic [13:0] last_idx;
  logic        have_last;
  logic [13:0] gap;
  logic        reject, accept;
  logic        s1_valid;
  evt_t        s1_evt;

  assign gap    = pk_idx - last_idx;
  assign reject = (pk_width < MIN_WIDTH) || (have_last && (gap < MIN_GAP));
  assign accept = pk_valid && !reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx     <= '0;
      have_last    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_evt       <= '0;
      reject_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_evt.amp      <= pk_amp;
        s1_evt.idx      <= pk_idx;
        s1_evt.width    <= pk_width;
        s1_evt.interval <= have_last ? gap : 14'd0;
        s1_evt.first    <= !have_last;
        last_idx        <= pk_idx;
        have_last       <= 1'b1;
      end
      if (pk_valid && reject && reject_count != 8'hFF)
        reject_count <= reject_count + 8'd1;
    end
  end

  // Stage 2: FIFO with wrap-bit pointers
  evt_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, push, pop, drop;
  evt_t        head;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (fill_level != 7'd0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign push      = s1_valid && (!full || pop);
  assign drop      = s1_valid && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s1_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 7'd1;
        2'b01:   fill_level <= fill_level - 7'd1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Clear beats a coincident drop.
  always_ff @(posedge clk) begin
    if (rst || clr_ovf) begin
      drop_count <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Outputs are forced to zero when empty so stale/unwritten storage never leaks out.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign out_amp      = out_valid ? head.amp      : '0;
  assign out_idx      = out_valid ? head.idx      : '0;
  assign out_width    = out_valid ? head.width    : '0;
  assign out_interval = out_valid ? head.interval : '0;
  assign out_first    = out_valid ? head.first    : 1'b0;

`ifdef PEAK_FIFO_STATS_EN
  logic signed [14:0] mi_diff;
  assign mi_diff = $signed({1'b0, gap}) - $signed({1'b0, mean_interval});

  always_ff @(posedge clk) begin
    if (rst) begin
      max_amp       <= 16'sh8000;
      accept_count  <= '0;
      mean_interval <= '0;
    end else begin
      if (clr_ovf)
        max_amp <= 16'sh8000;
      else if (accept && ($signed(pk_amp) > max_amp))
        max_amp <= $signed(pk_amp);
      if (accept) accept_count <= accept_count + 16'd1;
      if (accept && have_last)
        mean_interval <= mean_interval + 14'(mi_diff >>> 3);
    end
  end
`endif

endmodule

// File: tb/tb_peak_event_fifo.sv
// Scoreboard bench for peak_event_fifo: queue-level reference model, directed cases then random traffic.
module tb_peak_event_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        pk_valid = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [15:0] pk_amp = '0;
  logic [13:0] pk_idx = '0;
  logic [7:0]  pk_width = '0;
  logic        out_valid, out_first, ovf_sticky;
  logic [15:0] out_amp;
  logic [13:0] out_idx, out_interval;
  logic [7:0]  out_width, drop_count, reject_count;
  logic [6:0]  fill_level;

  peak_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pk_valid(pk_valid), .pk_amp(pk_amp), .pk_idx(pk_idx),
    .pk_width(pk_width), .out_valid(out_valid), .out_ready(out_ready), .out_amp(out_amp),
    .out_idx(out_idx), .out_width(out_width), .out_interval(out_interval),
    .out_first(out_first), .fill_level(fill_level), .drop_count(drop_count),
    .reject_count(reject_count), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int amp; int idx; int width; int interval; bit first; } ev_t;

  ev_t exp_q[$];
  int  vectors = 0, errors = 0;

  // Reference model state
  int  m_cnt, m_last, m_drop, m_rej;
  bit  m_have_last, m_ovf, m_s1_pend, m_live = 1'b0;
  ev_t m_s1;
  bit  m_pop, m_push, m_dropped;
  int  m_gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; m_last = 0; m_drop = 0; m_rej = 0;
      m_have_last = 0; m_ovf = 0; m_s1_pend = 0; m_live = 1;
    end else begin
      m_pop = (m_cnt > 0) && out_ready;
      m_push = 0; m_dropped = 0;
      if (m_s1_pend) begin
        if (m_cnt < DEPTH || m_pop) begin exp_q.push_back(m_s1); m_push = 1; end
        else m_dropped = 1;
      end
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      if (clr_ovf) begin m_drop = 0; m_ovf = 0; end
      else if (m_dropped) begin if (m_drop < 255) m_drop++; m_ovf = 1; end
      m_s1_pend = 0;
      if (pk_valid) begin
        m_gap = (int'(pk_idx) - m_last + 16384) % 16384;
        if (int'(pk_width) < 2 || (m_have_last && m_gap < 16)) begin
          if (m_rej < 255) m_rej++;
        end else begin
          m_s1 = '{amp: int'(pk_amp), idx: int'(pk_idx), width: int'(pk_width),
                   interval: m_have_last ? m_gap : 0, first: !m_have_last};
          m_s1_pend = 1;
          m_last = int'(pk_idx);
          m_have_last = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      chk("fill_level", 32'(fill_level), m_cnt);
      chk("drop_count", 32'(drop_count), m_drop);
      chk("reject_count", 32'(reject_count), m_rej);
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 32'(out_valid), 0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("head.amp", 32'(out_amp), e.amp);
          chk("head.idx", 32'(out_idx), e.idx);
          chk("head.width", 32'(out_width), e.width);
          chk("head.interval", 32'(out_interval), e.interval);
          chk("head.first", 32'(out_first), 32'(e.first));
        end
      end
    end
  end

  task automatic pk(input int amp, input int idx, input int width);
    @(posedge clk); #1;
    pk_valid = 1'b1; pk_amp = 16'(amp); pk_idx = 14'(idx); pk_width = 8'(width);
    @(posedge clk); #1;
    pk_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((m_cnt != 0 || m_s1_pend) && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("drain_timeout", 32'(n >= 200), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".fill_level"}, 32'(fill_level), 0);
    chk({tag, ".drop_count"}, 32'(drop_count), 0);
    chk({tag, ".reject_count"}, 32'(reject_count), 0);
    chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 0);
    chk({tag, ".out_amp"}, 32'(out_amp), 0);
    chk({tag, ".out_first"}, 32'(out_first), 0);
  endtask

  initial begin
    int ridx;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");

    // Single event: two-edge latency into an empty FIFO
    out_ready = 1'b1;
    pk(16'h0380, 100, 5);
    @(negedge clk);
    chk("latency.early", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency.valid", 32'(out_valid), 1);
    chk("single.amp", 32'(out_amp), 32'h0380);
    chk("single.first", 32'(out_first), 1);
    chk("single.interval", 32'(out_interval), 0);

    // Refractory, wrap-around, width filter
    pk(16'h0100, 110, 5);
    pk(16'h0200, 130, 5);
    @(negedge clk);
    chk("refractory.reject_count", 32'(reject_count), 1);
    pk(16'h0300, 16380, 4);
    pk(16'h0400, 20, 4);
    pk(16'h0500, 100, 1);
    pk(16'h0600, 60, 3);
    wait_drain();

    // Overflow: 10 accepted events into a stalled 8-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) pk(i * 16, 1000 + 20 * i, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf.fill_level", 32'(fill_level), 8);
    chk("ovf.drop_count", 32'(drop_count), 2);
    chk("ovf.ovf_sticky", 32'(ovf_sticky), 1);

    // Full FIFO: push coincides with pop
    @(posedge clk); #1;
    pk_valid = 1'b1; pk_amp = 16'h7777; pk_idx = 14'd2000; pk_width = 8'd6;
    @(posedge clk); #1;
    pk_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pushpop.fill_level", 32'(fill_level), 8);
    chk("pushpop.drop_count", 32'(drop_count), 2);
    wait_drain();
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("clr.drop_count", 32'(drop_count), 0);
    chk("clr.ovf_sticky", 32'(ovf_sticky), 0);

    // Random traffic with stalls, back-to-back pulses and occasional clears
    ridx = 3000;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      pk_valid = ($urandom_range(0, 2) == 0);
      ridx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 16383))
                                          : (ridx + int'($urandom_range(0, 40))) % 16384;
      pk_idx   = 14'(ridx);
      pk_amp   = 16'($urandom);
      pk_width = 8'($urandom_range(0, 6));
      out_ready = ((i % 100) < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
      clr_ovf  = ($urandom_range(0, 40) == 0);
    end
    @(posedge clk); #1;
    pk_valid = 1'b0; clr_ovf = 1'b0;
    wait_drain();

    // Reset mid-stream, with a coincident peak strobe that must be ignored
    out_ready = 1'b0;
    pk(16'h1111, 5000, 4);
    pk(16'h2222, 5100, 4);
    pk(16'h3333, 5200, 1);
    @(posedge clk); #1;
    rst = 1'b1; pk_valid = 1'b1; pk_idx = 14'd5300; pk_width = 8'd5;
    @(posedge clk); #1;
    rst = 1'b0; pk_valid = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    out_ready = 1'b1;
    pk(16'h0444, 500, 4);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset.first", 32'(out_first), 1);
    wait_drain();
    chk("final.queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
